relu_maxpool_stage: RTL and testbench

Downstream consumer of the convolution-with-adder stage. Takes the conv result stream in raster order, applies ReLU, and performs 2x2 max pooling with stride 2. Emits one pooled value per completed 2x2 window, in raster order, to the next layer. There is no backpressure; the block follows the same valid-qualified streaming style as the conv stage.

---
 rtl/relu_maxpool_stage.sv | 67 ++++++
 tb/tb_relu_maxpool_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_stage.sv
// relu_maxpool_stage: ReLU then 2x2 stride-2 max pooling over a raster-order conv result stream
// Ports: clock (rising edge), reset_n (async active-low),
//        data_in/isValid (signed conv pixel + qualifier),
//        data_out/outValid (pooled value, one-cycle pulse per window),
//        frameDone (one-cycle pulse after the final pixel of a frame)
module relu_maxpool_stage #(
   parameter int bitwidth     = 16,
   parameter int convOutWidth = 9
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic signed [bitwidth-1:0] data_in,
   input  logic                       isValid,
   output logic        [bitwidth-1:0] data_out,
   output logic                       outValid,
   output logic                       frameDone
);
   localparam int poolWidth = convOutWidth / 2;
   localparam int cw = $clog2(convOutWidth);
   localparam int pw = (poolWidth > 1) ? $clog2(poolWidth) : 1;
   localparam bit odd_map = (convOutWidth % 2) == 1;
   logic [cw-1:0] col, row;
   logic [bitwidth-1:0] hold, r, p, above, pooled;
   logic [bitwidth-1:0] linebuf [poolWidth];
   logic [pw-1:0] addr;
   logic last_col, last_row, skip_col, skip_row;
   // r is non-negative after ReLU, so all maxima below are unsigned compares
   always_comb begin
      r        = data_in[bitwidth-1] ? '0 : data_in;
      p        = (hold > r) ? hold : r;
      addr     = pw'(col >> 1);
      above    = linebuf[addr];
      pooled   = (above > p) ? above : p;
      last_col = col == cw'(convOutWidth - 1);
      last_row = row == cw'(convOutWidth - 1);
      // with an odd map the trailing column/row has no partner and is dropped
      skip_col = odd_map && last_col;
      skip_row = odd_map && last_row;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col       <= '0;
         row       <= '0;
         hold      <= '0;
         data_out  <= '0;
         outValid  <= 1'b0;
         frameDone <= 1'b0;
      end else begin
         outValid  <= 1'b0;
         frameDone <= 1'b0;
         if (isValid) begin
            col       <= last_col ? '0 : col + 1'b1;
            row       <= last_col ? (last_row ? '0 : row + 1'b1) : row;
            frameDone <= last_col && last_row;
            if (!col[0] && !skip_col) hold <= r;
            if (col[0] && row[0]) begin
               data_out <= pooled;
               outValid <= 1'b1;
            end
         end
      end
   end
   // line buffer holds the top-row pair maxima; never read before written, so no reset
   always_ff @(posedge clock) begin
      if (isValid && col[0] && !row[0] && !skip_row) linebuf[addr] <= p;
   end
endmodule

// File: tb/tb_relu_maxpool_stage.sv
// tb_relu_maxpool_stage: randomized and directed bench for relu_maxpool_stage against a window-level model
module tb_relu_maxpool_stage;
   localparam int W = 9, P = W / 2, N = W * W;
   typedef int iq_t[$];
   logic clock = 0, reset_n = 1, isValid = 0;
   logic signed [15:0] data_in = 0;
   logic [15:0] data_out;
   logic outValid, frameDone;
   int acc = 0, xbad = 0, pass = 0, total = 0, base = 0;
   int ov_v[$], ov_p[$], fd_p[$], exp_v[$], exp_p[$];
   int ramp_exp[16] = '{11, 13, 15, 17, 29, 31, 33, 35, 47, 49, 51, 53, 65, 67, 69, 71};

   relu_maxpool_stage #(.bitwidth(16), .convOutWidth(W)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .isValid(isValid),
      .data_out(data_out), .outValid(outValid), .frameDone(frameDone)
   );

   always #5 clock = ~clock;

   // acc = number of pixels accepted so far; outputs are tagged with it to check latency
   always @(posedge clock) if (reset_n && isValid) acc <= acc + 1;

   always @(negedge clock) begin
      if ($isunknown(data_out) || $isunknown(outValid) || $isunknown(frameDone)) xbad <= xbad + 1;
      if (outValid) begin
         ov_v.push_back(int'(data_out));
         ov_p.push_back(acc);
      end
      if (frameDone) fd_p.push_back(acc);
   end

   function automatic iq_t ramp(input int s, input int n);
      iq_t q;
      for (int k = 0; k < n; k++) q.push_back(s + k);
      return q;
   endfunction

   // Each window's output is the max of 0 and its four pixels, emitted right after its
   // bottom-right pixel (1-based index (2i+1)*W + 2j + 2 within the frame).
   task automatic model(input iq_t f);
      exp_v.delete();
      exp_p.delete();
      for (int fr = 0; fr < f.size() / N; fr++)
         for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++) begin
               int m = 0;
               for (int di = 0; di < 2; di++)
                  for (int dj = 0; dj < 2; dj++)
                     if (f[fr * N + (2 * i + di) * W + 2 * j + dj] > m)
                        m = f[fr * N + (2 * i + di) * W + 2 * j + dj];
               exp_v.push_back(m);
               exp_p.push_back(fr * N + (2 * i + 1) * W + 2 * j + 2);
            end
   endtask

   task automatic start();
      ov_v.delete();
      ov_p.delete();
      fd_p.delete();
      base = acc;
   endtask

   task automatic feed(input iq_t f, input iq_t st, input int tail);
      for (int k = 0; k < f.size(); k++) begin
         @(negedge clock);
         data_in = 16'(f[k]);
         isValid = 1;
         if (k < st.size())
            for (int s = 0; s < st[k]; s++) begin
               @(negedge clock);
               isValid = 0;
               data_in = 'x;
            end
      end
      @(negedge clock);
      isValid = 0;
      data_in = 0;
      repeat (tail) @(negedge clock);
   endtask

   task automatic test_reset();
      #1 reset_n = 0;
      #2;
      total++; if (data_out !== 16'd0) $display("FAIL reset data_out: got %0d want 0", data_out); else pass++;
      total++; if (outValid !== 1'b0) $display("FAIL reset outValid: got %b want 0", outValid); else pass++;
      total++; if (frameDone !== 1'b0) $display("FAIL reset frameDone: got %b want 0", frameDone); else pass++;
      repeat (2) @(negedge clock);
      reset_n = 1;
   endtask

   task automatic test_ramp();
      iq_t st;
      start();
      model(ramp(1, N));
      feed(ramp(1, N), st, 2);
      total++; if (ov_v.size() !== 16) $display("FAIL ramp count: got %0d want 16", ov_v.size()); else pass++;
      for (int k = 0; k < 16; k++) begin
         total++;
         if (ov_v[k] !== ramp_exp[k] || ov_p[k] - base !== exp_p[k])
            $display("FAIL ramp out%0d: got %0d after input %0d, want %0d after input %0d", k, ov_v[k], ov_p[k] - base, ramp_exp[k], exp_p[k]);
         else pass++;
      end
      total++; if (fd_p.size() !== 1 || fd_p[0] - base !== 81) $display("FAIL ramp frameDone: got %0d pulses first after %0d, want 1 after 81", fd_p.size(), fd_p[0] - base); else pass++;
   endtask

   task automatic test_negative();
      iq_t f, st;
      for (int k = 0; k < N; k++) f.push_back(-5);
      start();
      model(f);
      feed(f, st, 2);
      total++; if (ov_v.size() !== 16) $display("FAIL negative count: got %0d want 16", ov_v.size()); else pass++;
      for (int k = 0; k < 16; k++) begin
         total++;
         if (ov_v[k] !== 0 || ov_p[k] - base !== exp_p[k])
            $display("FAIL negative out%0d: got %0d after %0d, want 0 after %0d", k, ov_v[k], ov_p[k] - base, exp_p[k]);
         else pass++;
      end
      total++; if (fd_p.size() !== 1 || fd_p[0] - base !== 81) $display("FAIL negative frameDone: got %0d pulses, want 1 after 81", fd_p.size()); else pass++;
   endtask

   task automatic test_mixed();
      iq_t f, st;
      for (int k = 0; k < N; k++) f.push_back(0);
      f[0] = -3; f[1] = 7; f[W] = 2; f[W + 1] = -100;
      start();
      model(f);
      feed(f, st, 2);
      total++; if (ov_v.size() !== 16) $display("FAIL mixed count: got %0d want 16", ov_v.size()); else pass++;
      for (int k = 0; k < 16; k++) begin
         total++;
         if (ov_v[k] !== (k == 0 ? 7 : 0) || ov_p[k] - base !== exp_p[k])
            $display("FAIL mixed out%0d: got %0d after %0d, want %0d after %0d", k, ov_v[k], ov_p[k] - base, k == 0 ? 7 : 0, exp_p[k]);
         else pass++;
      end
   endtask

   task automatic test_stall();
      iq_t st;
      int x0;
      for (int k = 0; k < N; k++) st.push_back(k == 18 ? 3 : (k == 38 ? 1 : 0));
      start();
      x0 = xbad;
      model(ramp(1, N));
      feed(ramp(1, N), st, 2);
      total++; if (ov_v.size() !== 16) $display("FAIL stall count: got %0d want 16", ov_v.size()); else pass++;
      for (int k = 0; k < 16; k++) begin
         total++;
         if (ov_v[k] !== ramp_exp[k] || ov_p[k] - base !== exp_p[k])
            $display("FAIL stall out%0d: got %0d after %0d, want %0d after %0d", k, ov_v[k], ov_p[k] - base, ramp_exp[k], exp_p[k]);
         else pass++;
      end
      total++; if (xbad !== x0) $display("FAIL stall xcheck: got %0d unknown samples want 0", xbad - x0); else pass++;
   endtask

   task automatic test_reset_mid();
      iq_t st;
      start();
      feed(ramp(1, 40), st, 0);
      total++; if (data_out !== 16'd35) $display("FAIL midreset pre data_out: got %0d want 35", data_out); else pass++;
      #2 reset_n = 0;
      #1;
      total++; if (data_out !== 16'd0) $display("FAIL midreset data_out: got %0d want 0", data_out); else pass++;
      total++; if (outValid !== 1'b0 || frameDone !== 1'b0) $display("FAIL midreset flags: got %b%b want 00", outValid, frameDone); else pass++;
      @(negedge clock);
      reset_n = 1;
      start();
      model(ramp(1, N));
      feed(ramp(1, N), st, 2);
      total++; if (ov_v.size() !== 16) $display("FAIL midreset count: got %0d want 16", ov_v.size()); else pass++;
      for (int k = 0; k < 16; k++) begin
         total++;
         if (ov_v[k] !== ramp_exp[k] || ov_p[k] - base !== exp_p[k])
            $display("FAIL midreset out%0d: got %0d after %0d, want %0d after %0d", k, ov_v[k], ov_p[k] - base, ramp_exp[k], exp_p[k]);
         else pass++;
      end
      total++; if (fd_p.size() !== 1 || fd_p[0] - base !== 81) $display("FAIL midreset frameDone: got %0d pulses, want 1 after 81", fd_p.size()); else pass++;
   endtask

   task automatic test_back_to_back();
      iq_t f, st;
      f = ramp(1, N);
      for (int k = 0; k < N; k++) f.push_back(101 + k);
      start();
      model(f);
      feed(f, st, 2);
      total++; if (ov_v.size() !== 32) $display("FAIL b2b count: got %0d want 32", ov_v.size()); else pass++;
      for (int k = 0; k < 32; k++) begin
         total++;
         if (ov_v[k] !== ramp_exp[k % 16] + (k >= 16 ? 100 : 0) || ov_p[k] - base !== exp_p[k])
            $display("FAIL b2b out%0d: got %0d after %0d, want %0d after %0d", k, ov_v[k], ov_p[k] - base, ramp_exp[k % 16] + (k >= 16 ? 100 : 0), exp_p[k]);
         else pass++;
      end
      total++;
      if (fd_p.size() !== 2 || fd_p[0] - base !== 81 || fd_p[1] - fd_p[0] !== 81)
         $display("FAIL b2b frameDone: got %0d pulses, first after %0d, want 2 at 81 and 162", fd_p.size(), fd_p[0] - base);
      else pass++;
   endtask

   task automatic test_random();
      iq_t f, st;
      for (int k = 0; k < 2 * N; k++) begin
         f.push_back(int'($urandom_range(0, 65535)) - 32768);
         st.push_back($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0);
      end
      start();
      model(f);
      feed(f, st, 2);
      total++; if (ov_v.size() !== 32) $display("FAIL random count: got %0d want 32", ov_v.size()); else pass++;
      for (int k = 0; k < 32; k++) begin
         total++;
         if (ov_v[k] !== exp_v[k] || ov_p[k] - base !== exp_p[k])
            $display("FAIL random out%0d: got %0d after %0d, want %0d after %0d", k, ov_v[k], ov_p[k] - base, exp_v[k], exp_p[k]);
         else pass++;
      end
      total++; if (fd_p.size() !== 2) $display("FAIL random frameDone: got %0d pulses want 2", fd_p.size()); else pass++;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_negative();
      test_mixed();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_random();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
